// File: rtl/eth_ingress_pkt_buf_pkg.sv
// Shared types for the Ethernet ingress packet buffer.
package eth_ingress_pkt_buf_pkg;

  localparam int WORD_W = 32;

  // One buffer entry: packet delimiters travel alongside the data word.
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [WORD_W-1:0] data;
  } eth_word_t;

  // Write-side packet FSM.
  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    DROP
  } eth_wr_state_e;

endpackage

// File: rtl/eth_ingress_pkt_buf_if.sv
// Port-side and core-side signals of one ingress buffer instance.
interface eth_ingress_pkt_buf_if #(
  parameter int CNT_W = 16
);
  import eth_ingress_pkt_buf_pkg::*;

  logic [WORD_W-1:0] inData;
  logic              inSop;
  logic              inEop;
  logic              portStall;
  logic [WORD_W-1:0] outData;
  logic              outSop;
  logic              outEop;
  logic              outValid;
  logic              upStall;
  logic [CNT_W-1:0]  dropCnt;
  logic [CNT_W-1:0]  pktCnt;

  // Environment side: drives the ingress stream and the core stall.
  modport master (
    output inData, inSop, inEop, portStall,
    input  outData, outSop, outEop, outValid, upStall, dropCnt, pktCnt
  );

  // Buffer side.
  modport slave (
    input  inData, inSop, inEop, portStall,
    output outData, outSop, outEop, outValid, upStall, dropCnt, pktCnt
  );

endinterface

// File: rtl/eth_ingress_pkt_buf_ram.sv
// Simple dual-port packet storage: synchronous write, asynchronous read.
module eth_sdp_ram
  import eth_ingress_pkt_buf_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  eth_word_t         i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output eth_word_t         o_rdData
);

  eth_word_t r_mem [DEPTH];

  // Store one entry per enabled write cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/eth_ingress_pkt_buf.sv
// Store-and-forward ingress buffer: only fully received packets are released to the core.
module eth_ingress_pkt_buf
  import eth_ingress_pkt_buf_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STALL_THRESH = 4,
  parameter int CNT_W        = 16
) (
  input logic            clk,
  input logic            reset_n,
  eth_ingress_pkt_buf_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
  localparam ptr_t THRESH_P = ptr_t'(STALL_THRESH);
  localparam ptr_t ONE_P    = ptr_t'(1);

  eth_wr_state_e     r_state, w_stateNext;
  ptr_t              r_wrPtr, r_rdPtr, r_commitPtr;
  ptr_t              w_wrPtrNext, w_rdPtrNext, w_commitPtrNext;
  ptr_t              w_base, w_occBase, w_occNext, w_free;
  logic              w_we, w_full, w_wantWrite, w_abort, w_fullDrop, w_commit, w_rd;
  logic [CNT_W-1:0]  r_dropCnt, r_pktCnt, w_dropNext, w_pktNext;
  eth_word_t         w_wrWord, w_rdWord;
  logic [WORD_W-1:0] r_outData;
  logic              r_outSop, r_outEop, r_outValid, r_upStall;

  // Write FSM: decides whether the incoming word is stored, committed or discarded.
  // An aborted packet rewinds to commitPtr so the new SOP overwrites the orphaned words.
  always_comb begin
    w_stateNext     = r_state;
    w_we            = 1'b0;
    w_abort         = 1'b0;
    w_fullDrop      = 1'b0;
    w_commit        = 1'b0;
    w_wantWrite     = 1'b0;
    w_base          = r_wrPtr;
    w_wrPtrNext     = r_wrPtr;
    w_commitPtrNext = r_commitPtr;
    w_wrWord        = '{sop: bus.inSop, eop: bus.inEop, data: bus.inData};
    unique case (r_state)
      IDLE: begin
        w_wantWrite = bus.inSop;
      end
      IN_PKT: begin
        w_wantWrite = 1'b1;
        if (bus.inSop) begin
          w_abort = 1'b1;
          w_base  = r_commitPtr;
        end
      end
      DROP: begin
        if (bus.inSop) begin
          w_wantWrite = 1'b1;
        end else if (bus.inEop) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    w_occBase = w_base - r_rdPtr;
    w_full    = (w_occBase == DEPTH_P);
    if (w_wantWrite) begin
      if (w_full) begin
        w_fullDrop  = 1'b1;
        w_wrPtrNext = r_commitPtr;
        w_stateNext = bus.inEop ? IDLE : DROP;
      end else begin
        w_we        = 1'b1;
        w_wrPtrNext = w_base + ONE_P;
        if (bus.inEop) begin
          w_commit        = 1'b1;
          w_commitPtrNext = w_base + ONE_P;
          w_stateNext     = IDLE;
        end else begin
          w_stateNext = IN_PKT;
        end
      end
    end
  end

  // Next values of the drop (saturating) and packet (wrapping) counters.
  always_comb begin
    w_dropNext = r_dropCnt;
    if (w_abort && (w_dropNext != '1)) begin
      w_dropNext = w_dropNext + CNT_W'(1);
    end
    if (w_fullDrop && (w_dropNext != '1)) begin
      w_dropNext = w_dropNext + CNT_W'(1);
    end
    w_pktNext = w_commit ? (r_pktCnt + CNT_W'(1)) : r_pktCnt;
  end

  assign w_rd        = (r_rdPtr != r_commitPtr) && !bus.portStall;
  assign w_rdPtrNext = w_rd ? (r_rdPtr + ONE_P) : r_rdPtr;
  assign w_occNext   = w_wrPtrNext - w_rdPtrNext;
  assign w_free      = DEPTH_P - w_occNext;

  eth_sdp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .i_we     (w_we),
    .i_wrAddr (w_base[ADDR_W-1:0]),
    .i_wrData (w_wrWord),
    .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
    .o_rdData (w_rdWord)
  );

  // State, pointers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_commitPtr <= '0;
      r_dropCnt   <= '0;
      r_pktCnt    <= '0;
      r_outData   <= '0;
      r_outSop    <= 1'b0;
      r_outEop    <= 1'b0;
      r_outValid  <= 1'b0;
      r_upStall   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_wrPtr     <= w_wrPtrNext;
      r_rdPtr     <= w_rdPtrNext;
      r_commitPtr <= w_commitPtrNext;
      r_dropCnt   <= w_dropNext;
      r_pktCnt    <= w_pktNext;
      r_upStall   <= (w_free < THRESH_P);
      if (w_rd) begin
        r_outData  <= w_rdWord.data;
        r_outSop   <= w_rdWord.sop;
        r_outEop   <= w_rdWord.eop;
        r_outValid <= 1'b1;
      end else begin
        r_outSop   <= 1'b0;
        r_outEop   <= 1'b0;
        r_outValid <= 1'b0;
      end
    end
  end

  assign bus.outData  = r_outData;
  assign bus.outSop   = r_outSop;
  assign bus.outEop   = r_outEop;
  assign bus.outValid = r_outValid;
  assign bus.upStall  = r_upStall;
  assign bus.dropCnt  = r_dropCnt;
  assign bus.pktCnt   = r_pktCnt;

endmodule

// File: tb/tb_eth_ingress_pkt_buf.sv
// Scoreboard bench for the ingress packet buffer (DEPTH=16, STALL_THRESH=4).
module tb_eth_ingress_pkt_buf;
  import eth_ingress_pkt_buf_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          outCount = 0;
  logic [33:0] expQ[$];
  logic [33:0] monExp;
  logic [15:0] expDrop = '0;
  logic [15:0] expPkt = '0;

  eth_ingress_pkt_buf_if #(.CNT_W(16)) ifc ();

  eth_ingress_pkt_buf #(
    .DEPTH        (16),
    .STALL_THRESH (4),
    .CNT_W        (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pop the scoreboard whenever the buffer issues a word to the core.
  always @(negedge clk) begin
    if (reset_n && ifc.outValid) begin
      outCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", 64'({ifc.outSop, ifc.outEop, ifc.outData}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("out_word", 64'({ifc.outSop, ifc.outEop, ifc.outData}), 64'(monExp));
      end
    end
  end

  task automatic applyStimulus(input logic sop, input logic eop, input logic [31:0] data);
    @(negedge clk);
    ifc.inSop  = sop;
    ifc.inEop  = eop;
    ifc.inData = data;
  endtask

  task automatic sendPkt(input logic [31:0] base, input int len, input bit keep);
    for (int i = 0; i < len; i++) begin
      applyStimulus(i == 0, i == len - 1, base + 32'(i));
      if (keep) expQ.push_back({1'(i == 0), 1'(i == len - 1), base + 32'(i)});
    end
    if (keep) expPkt++;
    else expDrop++;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      ifc.inSop = 1'b0;
      ifc.inEop = 1'b0;
      ifc.inData = '0;
      if (expQ.size() == 0) break;
    end
    repeat (2) @(negedge clk);
    checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_dropCnt"}, 64'(ifc.dropCnt), 64'(expDrop));
    checkOutput({tag, "_pktCnt"}, 64'(ifc.pktCnt), 64'(expPkt));
  endtask

  initial begin
    bit found;
    int occ;
    ifc.inSop = 1'b0;
    ifc.inEop = 1'b0;
    ifc.inData = '0;
    ifc.portStall = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_outValid", 64'(ifc.outValid), 64'd0);
    checkOutput("rst_outData", 64'(ifc.outData), 64'd0);
    checkOutput("rst_upStall", 64'(ifc.upStall), 64'd0);
    checkOutput("rst_counters", 64'({ifc.dropCnt, ifc.pktCnt}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic 4-word packet with latency check
    sendPkt(32'hA0, 4, 1'b1);
    @(posedge clk); #1;
    checkOutput("t1_valid_edgeN", 64'(ifc.outValid), 64'd0);
    @(posedge clk); #1;
    checkOutput("t1_first_edgeN1", 64'({ifc.outValid, ifc.outSop, ifc.outData}), 64'({1'b1, 1'b1, 32'hA0}));
    drain("t1");

    // 6-word packet with a 3-cycle core stall after the second word
    sendPkt(32'h200, 6, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ifc.outValid && ifc.outData == 32'h201) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t2_second_word_seen", 64'(found), 64'd1);
    ifc.portStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("t2_stalled_valid", 64'(ifc.outValid), 64'd0);
    end
    ifc.portStall = 1'b0;
    drain("t2");
    checkOutput("t2_word_count", 64'(outCount), 64'd10);

    // Aborted packet: a new SOP mid-packet drops the partial one
    applyStimulus(1'b1, 1'b0, 32'hB0);
    applyStimulus(1'b0, 1'b0, 32'hB1);
    applyStimulus(1'b1, 1'b0, 32'hC0);
    applyStimulus(1'b0, 1'b1, 32'hC1);
    expQ.push_back({1'b1, 1'b0, 32'hC0});
    expQ.push_back({1'b0, 1'b1, 32'hC1});
    expDrop++;
    expPkt++;
    drain("t3");

    // Oversize packet is dropped, the following short one survives
    sendPkt(32'h400, 20, 1'b0);
    sendPkt(32'hD0, 2, 1'b1);
    drain("t4");

    // Back-pressure: fill with stall held, then release
    ifc.portStall = 1'b1;
    for (int w = 0; w < 20; w++) begin
      applyStimulus((w % 5) == 0, (w % 5) == 4, 32'h500 + 32'(w));
      if (w < 15) expQ.push_back({1'((w % 5) == 0), 1'((w % 5) == 4), 32'h500 + 32'(w)});
      @(posedge clk); #1;
      occ = (w < 16) ? (w + 1) : 15;
      checkOutput($sformatf("t5_upStall_w%0d", w), 64'(ifc.upStall), 64'(occ >= 13));
    end
    expPkt += 16'd3;
    expDrop++;
    applyStimulus(1'b0, 1'b0, 32'h0);
    ifc.portStall = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("t5_release_k%0d", k), 64'(ifc.upStall), 64'((15 - k) >= 13));
    end
    drain("t5");

    // Single-word packet
    sendPkt(32'hE0, 1, 1'b1);
    drain("t_single");

    // Reset mid-packet
    applyStimulus(1'b1, 1'b0, 32'hF0);
    applyStimulus(1'b0, 1'b0, 32'hF1);
    @(negedge clk);
    reset_n = 1'b0;
    ifc.inSop = 1'b0;
    ifc.inEop = 1'b0;
    ifc.inData = '0;
    @(posedge clk); #1;
    checkOutput("t6_outputs", 64'({ifc.outValid, ifc.outSop, ifc.outEop, ifc.upStall, ifc.outData}), 64'd0);
    checkOutput("t6_counters", 64'({ifc.dropCnt, ifc.pktCnt}), 64'd0);
    expDrop = '0;
    expPkt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'hF2);
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
